// File: rtl/spi_regs_if.sv
// Byte-level link between the SPI shifter stage and the register block.
// The shifter stage is the master: it frames and delivers bytes and takes tx_data back.
interface spi_regs_if #(
    parameter int size = 8
);
    logic            scs;
    logic            rx_valid;
    logic [size-1:0] rx_data;
    logic [size-1:0] tx_data;

    modport master (output scs, output rx_valid, output rx_data, input tx_data);
    modport slave  (input scs, input rx_valid, input rx_data, output tx_data);
endinterface

// File: rtl/spi_regs.sv
// Register file behind an SPI byte stream: command byte (rw + start address), then an
// auto-incrementing burst over 4 control registers (0..3) and 4 status inputs (4..7).
module spi_regs #(
    parameter int              size = 8,
    parameter logic [size-1:0] id   = 8'h81
) (
    input  logic              clk,
    input  logic              rst,
    spi_regs_if.slave         spi,
    output logic [4*size-1:0] ctrl,
    input  logic [4*size-1:0] stat,
    output logic              wr_stb,
    output logic [1:0]        wr_addr,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t     state;
    logic       write_frame;
    logic [2:0] addr;
    logic [2:0] next_addr;

    assign next_addr = addr + 3'd1;

    // Registers 0..3 are the control bank, 4..7 the live status inputs.
    function automatic logic [size-1:0] reg_read(input logic [2:0] a);
        if (a[2]) begin
            return stat[a[1:0]*size +: size];
        end
        return ctrl[a[1:0]*size +: size];
    endfunction

    // NOTE: every register here uses <= so all branches read the pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            write_frame <= 1'b0;
            addr        <= 3'd0;
            // NOTE: ctrl is built from flops, so it is cleared with the rest of the state.
            ctrl        <= '0;
            spi.tx_data <= id;
            wr_stb      <= 1'b0;
            wr_addr     <= 2'd0;
            busy        <= 1'b0;
        end else begin
            wr_stb <= 1'b0;
            if (!spi.scs) begin
                // Frame end has priority over any byte arriving in the same cycle.
                state       <= IDLE;
                busy        <= 1'b0;
                spi.tx_data <= id;
            end else begin
                case (state)
                    IDLE: begin
                        state       <= CMD;
                        busy        <= 1'b1;
                        spi.tx_data <= id;
                    end
                    CMD: begin
                        if (spi.rx_valid) begin
                            write_frame <= spi.rx_data[7];
                            addr        <= spi.rx_data[2:0];
                            state       <= DATA;
                            if (!spi.rx_data[7]) begin
                                spi.tx_data <= reg_read(spi.rx_data[2:0]);
                            end
                        end
                    end
                    DATA: begin
                        if (spi.rx_valid) begin
                            if (write_frame && !addr[2]) begin
                                ctrl[addr[1:0]*size +: size] <= spi.rx_data;
                                wr_stb                       <= 1'b1;
                                wr_addr                      <= addr[1:0];
                            end
                            addr <= next_addr;
                            if (!write_frame) begin
                                spi.tx_data <= reg_read(next_addr);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_regs.sv
// Scoreboarded bench for spi_regs: stimulus tasks update a frame-level register model and
// queue expected tx_data / write events; a monitor compares them as the DUT produces them.
module tb_spi_regs;

    localparam logic [7:0] ID = 8'h81;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ctrl;
    logic [31:0] stat;
    logic        wr_stb;
    logic [1:0]  wr_addr;
    logic        busy;

    spi_regs_if #(.size(8)) spi ();

    spi_regs #(.size(8), .id(ID)) dut (
        .clk    (clk),
        .rst    (rst),
        .spi    (spi.slave),
        .ctrl   (ctrl),
        .stat   (stat),
        .wr_stb (wr_stb),
        .wr_addr(wr_addr),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_tx[$];

    // Frame-level model: registers as an array, address as an integer walking mod 8.
    logic [7:0] m_ctrl[4];
    bit         m_cmd_done;
    bit         m_write;
    int         m_addr;
    logic [7:0] m_tx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_read(input int a);
        return (a < 4) ? m_ctrl[a] : stat[(a-4)*8 +: 8];
    endfunction

    function automatic logic [31:0] m_ctrl_packed();
        return {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]};
    endfunction

    initial begin : monitor
        bit         saw_rx;
        logic [7:0] e;
        wr_t        w;
        forever begin
            @(posedge clk);
            saw_rx = spi.rx_valid && rst;
            @(negedge clk);
            if (saw_rx) begin
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_data: byte seen with no expectation queued, got %h", spi.tx_data);
                end else begin
                    e = exp_tx.pop_front();
                    check("tx_data", spi.tx_data, e);
                end
            end
            if (wr_stb) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_stb: unexpected pulse, got addr %0d expected no pulse", wr_addr);
                end else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", wr_addr, w.a);
                    check("ctrl_written", ctrl[w.a*8 +: 8], w.d);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        spi.rx_valid = 1'b1;
        spi.rx_data  = b;
        if (spi.scs) begin
            if (!m_cmd_done) begin
                m_cmd_done = 1'b1;
                m_write    = b[7];
                m_addr     = int'(b[2:0]);
                if (!m_write) m_tx = m_read(m_addr);
            end else begin
                if (m_write && m_addr < 4) begin
                    m_ctrl[m_addr] = b;
                    exp_wr.push_back('{a: 2'(m_addr), d: b});
                end
                m_addr = (m_addr + 1) % 8;
                if (!m_write) m_tx = m_read(m_addr);
            end
        end
        exp_tx.push_back(m_tx);
        @(posedge clk);
        #1;
        spi.rx_valid = 1'b0;
    endtask

    task automatic start_frame();
        @(posedge clk);
        #1;
        spi.scs    = 1'b1;
        m_cmd_done = 1'b0;
        m_tx       = ID;
        @(posedge clk);
        @(negedge clk);
        check("busy_start", busy, 1'b1);
        check("tx_id_start", spi.tx_data, ID);
    endtask

    task automatic end_frame();
        @(posedge clk);
        #1;
        spi.scs = 1'b0;
        m_tx    = ID;
        @(posedge clk);
        @(negedge clk);
        check("busy_end", busy, 1'b0);
        check("tx_id_end", spi.tx_data, ID);
        check("ctrl_end", ctrl, m_ctrl_packed());
    endtask

    // scs drops in the same cycle a byte arrives: the byte must vanish.
    task automatic abort_frame(input logic [7:0] b);
        @(posedge clk);
        #1;
        spi.scs      = 1'b0;
        spi.rx_valid = 1'b1;
        spi.rx_data  = b;
        m_tx         = ID;
        exp_tx.push_back(ID);
        @(posedge clk);
        #1;
        spi.rx_valid = 1'b0;
        @(negedge clk);
        check("busy_abort", busy, 1'b0);
        check("tx_id_abort", spi.tx_data, ID);
        check("ctrl_abort", ctrl, m_ctrl_packed());
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin : stimulus
        int n;
        rst          = 1'b0;
        spi.scs      = 1'b0;
        spi.rx_valid = 1'b0;
        spi.rx_data  = '0;
        stat         = '0;
        for (int i = 0; i < 4; i++) m_ctrl[i] = '0;
        m_tx = ID;
        #12;
        check("rst_tx", spi.tx_data, ID);
        check("rst_ctrl", ctrl, 32'h0);
        check("rst_wr_stb", wr_stb, 1'b0);
        check("rst_wr_addr", wr_addr, 2'd0);
        check("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Byte outside a frame is ignored.
        send_byte(8'h80);

        // Write burst into ctrl[1], ctrl[2].
        start_frame();
        send_byte(8'h81);
        send_byte(8'h11);
        send_byte(8'h22);
        end_frame();
        check("burst_ctrl1", ctrl[15:8], 8'h11);
        check("burst_ctrl2", ctrl[23:16], 8'h22);

        // Read starting at 7 wraps to 0.
        stat = 32'hD4C3B2A1;
        start_frame();
        send_byte(8'h80);
        send_byte(8'h55);
        end_frame();
        start_frame();
        send_byte(8'h07);
        send_byte(8'h00);
        send_byte(8'h00);
        end_frame();

        // Write aimed at a status register is dropped.
        start_frame();
        send_byte(8'h84);
        send_byte(8'hFF);
        end_frame();

        // Abort on a data byte of a write frame.
        start_frame();
        send_byte(8'h83);
        abort_frame(8'h99);
        check("abort_ctrl3", ctrl[31:24], 8'h00);

        // Reset mid-frame, then the still-active frame restarts with a command byte.
        start_frame();
        send_byte(8'h80);
        send_byte(8'hAA);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_ctrl[i] = '0;
        m_cmd_done = 1'b0;
        m_tx       = ID;
        #1;
        check("midrst_ctrl", ctrl, 32'h0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_tx", spi.tx_data, ID);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("postrst_busy", busy, 1'b1);
        send_byte(8'h82);
        send_byte(8'h33);
        end_frame();
        check("postrst_ctrl", ctrl, 32'h0033_0000);

        // Randomized frames.
        for (int f = 0; f < 150; f++) begin
            stat = $urandom;
            if ($urandom_range(0, 7) == 0) send_byte(8'($urandom));
            start_frame();
            send_byte(8'($urandom));
            n = $urandom_range(0, 6);
            for (int k = 0; k < n; k++) send_byte(8'($urandom));
            if ($urandom_range(0, 3) == 0) abort_frame(8'($urandom));
            else end_frame();
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_tx.size() != 0 || exp_wr.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d tx and %0d writes left, expected 0 and 0", exp_tx.size(), exp_wr.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
